// File: rtl/dest_scoreboard_pkg.sv
// Shared pipeline constants: register file geometry and the hard-wired
// zero register. The destination pipeline registers and the scoreboard
// both take these values from here so that they always agree.
package dest_scoreboard_pkg;

   // Number of architectural registers.
   localparam int NREGS = 32;

   // Width of a register address.
   localparam int AW = 5;

   // Register 0 always reads as zero, so it is never tracked as pending.
   localparam logic [AW-1:0] REG_ZERO = '0;

endpackage : dest_scoreboard_pkg

// File: rtl/sb_decode.sv
// Binary-to-one-hot decoder with an enable input. When the enable is low,
// every output bit is 0. The scoreboard uses one instance for the set path
// and one for the clear path.
module sb_decode #(
   parameter int N = 32,
   parameter int W = 5
) (
   input  logic         en_i,
   input  logic [W-1:0] addr_i,
   output logic [N-1:0] oh_o
);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dec
         // Each output bit is high only when enabled and its index is addressed.
         assign oh_o[gi] = en_i & (addr_i == W'(gi));
      end
   endgenerate

endmodule : sb_decode

// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard. It tracks which architectural registers
// have a write in flight and stalls issue on RAW and WAW hazards.
// A writeback in the same cycle is bypassed into the hazard check, so a
// waiting instruction can issue in the same cycle its operand retires.
// issue_ready is combinational and also acts as the load enable for the
// downstream destination register. A stalled request is held upstream;
// this block keeps no copy of it.
module dest_scoreboard
   import dest_scoreboard_pkg::*;
#(
   parameter int NREGS = dest_scoreboard_pkg::NREGS,
   parameter int AW    = dest_scoreboard_pkg::AW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rd,
   input  logic          issue_we,
   input  logic [AW-1:0] issue_rs1,
   input  logic [AW-1:0] issue_rs2,
   input  logic          use_rs1,
   input  logic          use_rs2,
   output logic          issue_ready,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_rd,
   input  logic          flush,
   output logic [AW:0]   busy_cnt,
   output logic          err_spurious
);

   // Register 0, widened or narrowed to this instance's address width.
   localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             err_q, err_d;

   logic [NREGS-1:0] wb_oh;      // one-hot of the writeback target
   logic [NREGS-1:0] set_oh;     // one-hot of an accepted, tracked issue
   logic [NREGS-1:0] busy_byp;   // busy as it looks after this cycle's writeback
   logic [NREGS-1:0] clr_vec;    // writeback that hits a pending bit
   logic [NREGS-1:0] set_eff;    // set that turns an idle bit busy
   logic [NREGS-1:0] clr_eff;    // clear that is not overridden by a set
   logic             hazard;
   logic             set_en;

   // Clear path: the decoder follows wb_valid so the bypass still sees the
   // writeback. Flush masking is applied later in the next-state logic.
   sb_decode #(.N(NREGS), .W(AW)) u_clr_dec (
      .en_i   (wb_valid),
      .addr_i (wb_rd),
      .oh_o   (wb_oh)
   );

   // Set path: only an accepted writer of a non-zero register is tracked.
   sb_decode #(.N(NREGS), .W(AW)) u_set_dec (
      .en_i   (set_en),
      .addr_i (issue_rd),
      .oh_o   (set_oh)
   );

   assign busy_byp = busy_q & ~wb_oh;

   assign hazard = (busy_byp[issue_rs1] & use_rs1)
                 | (busy_byp[issue_rs2] & use_rs2)
                 | (busy_byp[issue_rd]  & issue_we);

   assign issue_ready = issue_valid & ~hazard & ~flush;

   assign set_en  = issue_valid & issue_ready & issue_we & (issue_rd != RZ);
   assign clr_vec = wb_oh & busy_q;

   // A set that targets a bit being cleared in the same cycle wins.
   // That pair leaves the bit busy and the count unchanged.
   assign set_eff = set_oh & ~busy_q;
   assign clr_eff = clr_vec & ~set_oh;

   // Next-state logic for the busy vector, the pending count and the sticky error flag.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (flush) begin
         // Flush drops every pending write. The issue and writeback ports
         // are ignored this cycle, and the error flag keeps its value.
         busy_d = '0;
         cnt_d  = '0;
      end else begin
         busy_d    = (busy_q & ~clr_vec) | set_oh;
         busy_d[0] = 1'b0;
         cnt_d     = cnt_q + {{AW{1'b0}}, |set_eff} - {{AW{1'b0}}, |clr_eff};
         if (wb_valid && (wb_rd != RZ) && !busy_q[wb_rd]) begin
            err_d = 1'b1;
         end
      end
   end

   // State register. An active-low reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign busy_cnt     = cnt_q;
   assign err_spurious = err_q;

endmodule : dest_scoreboard

// File: tb/tb_dest_scoreboard.sv
// Directed testbench for dest_scoreboard. The stimulus process drives one
// cycle of inputs just after each rising edge. For that cycle it queues the
// expected issue_ready, busy_cnt and err_spurious. A separate monitor pops
// one expectation at every falling edge and compares it with the outputs.
module tb_dest_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic       issue_valid, issue_we, use_rs1, use_rs2, wb_valid, flush;
   logic [4:0] issue_rd, issue_rs1, issue_rs2, wb_rd;
   logic       issue_ready, err_spurious;
   logic [5:0] busy_cnt;

   typedef struct {
      string      name;
      logic       rdy;
      logic [5:0] cnt;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   txn   = 0;

   always #5 clk = ~clk;

   dest_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_we     (issue_we),
      .issue_rs1    (issue_rs1),
      .issue_rs2    (issue_rs2),
      .use_rs1      (use_rs1),
      .use_rs2      (use_rs2),
      .issue_ready  (issue_ready),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .flush        (flush),
      .busy_cnt     (busy_cnt),
      .err_spurious (err_spurious)
   );

   // Drive one cycle of inputs shortly after the rising edge and queue what
   // the outputs must show during that cycle.
   task automatic cyc(input string nm, input logic rst,
                      input logic v, input logic [4:0] rd, input logic we,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic wbv, input logic [4:0] wbrd, input logic fl,
                      input logic erdy, input logic [5:0] ecnt, input logic eerr);
      exp_t e;
      @(posedge clk);
      #1;
      reset       = rst;
      issue_valid = v;
      issue_rd    = rd;
      issue_we    = we;
      issue_rs1   = rs1;
      use_rs1     = u1;
      issue_rs2   = rs2;
      use_rs2     = u2;
      wb_valid    = wbv;
      wb_rd       = wbrd;
      flush       = fl;
      e.name = nm;
      e.rdy  = erdy;
      e.cnt  = ecnt;
      e.err  = eerr;
      exp_q.push_back(e);
   endtask

   // Monitor: sample mid-cycle and compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d %s: rdy=%0d cnt=%0d err=%0d", txn, e.name,
                     issue_ready, busy_cnt, err_spurious);
            total++;
            if (issue_ready !== e.rdy) begin
               bad++;
               $display("FAIL %s issue_ready got %0d want %0d", e.name, issue_ready, e.rdy);
            end
            total++;
            if (busy_cnt !== e.cnt) begin
               bad++;
               $display("FAIL %s busy_cnt got %0d want %0d", e.name, busy_cnt, e.cnt);
            end
            total++;
            if (err_spurious !== e.err) begin
               bad++;
               $display("FAIL %s err_spurious got %0d want %0d", e.name, err_spurious, e.err);
            end
         end
      end
   end

   initial begin
      int waited;
      reset = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_we = 1'b0;
      issue_rs1 = '0; issue_rs2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
      wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

      //   name           rst v  rd we rs1 u1 rs2 u2 wbv wbrd fl  rdy cnt err
      cyc("rst_idle",     0,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  0);
      cyc("rst_rdy",      0,  1, 5, 1, 0,  0, 0,  0, 0,  0,   0,  1,  0,  0);
      cyc("iss_r5",       1,  1, 5, 1, 0,  0, 0,  0, 0,  0,   0,  1,  0,  0);
      cyc("stall_rs1_a",  1,  1, 0, 0, 5,  1, 0,  0, 0,  0,   0,  0,  1,  0);
      cyc("stall_rs1_b",  1,  1, 0, 0, 5,  1, 0,  0, 0,  0,   0,  0,  1,  0);
      cyc("byp_wb5",      1,  1, 0, 0, 5,  1, 0,  0, 1,  5,   0,  1,  1,  0);
      cyc("idle_a",       1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  0);
      cyc("iss_r7",       1,  1, 7, 1, 0,  0, 0,  0, 0,  0,   0,  1,  0,  0);
      cyc("set_clr_r7",   1,  1, 7, 1, 0,  0, 0,  0, 1,  7,   0,  1,  1,  0);
      cyc("idle_b",       1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  1,  0);
      cyc("stall_rs2_7",  1,  1, 0, 0, 0,  0, 7,  1, 0,  0,   0,  0,  1,  0);
      cyc("wb_r7",        1,  0, 0, 0, 0,  0, 0,  0, 1,  7,   0,  0,  1,  0);
      cyc("idle_c",       1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  0);
      cyc("iss_r0",       1,  1, 0, 1, 0,  0, 0,  0, 0,  0,   0,  1,  0,  0);
      cyc("idle_d",       1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  0);
      cyc("wb_r0",        1,  0, 0, 0, 0,  0, 0,  0, 1,  0,   0,  0,  0,  0);
      cyc("idle_e",       1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  0);
      cyc("wb_r9_idle",   1,  0, 0, 0, 0,  0, 0,  0, 1,  9,   0,  0,  0,  0);
      cyc("err_set",      1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  1);
      cyc("iss_r3",       1,  1, 3, 1, 0,  0, 0,  0, 0,  0,   0,  1,  0,  1);
      cyc("iss_r4",       1,  1, 4, 1, 0,  0, 0,  0, 0,  0,   0,  1,  1,  1);
      cyc("iss_r6",       1,  1, 6, 1, 0,  0, 0,  0, 0,  0,   0,  1,  2,  1);
      cyc("flush",        1,  1,10, 1, 0,  0, 0,  0, 1,  3,   1,  0,  3,  1);
      cyc("post_flush",   1,  1, 0, 0, 3,  1, 0,  0, 0,  0,   0,  1,  0,  1);
      cyc("iss_r8",       1,  1, 8, 1, 0,  0, 0,  0, 0,  0,   0,  1,  0,  1);
      cyc("iss_r11",      1,  1,11, 1, 0,  0, 0,  0, 0,  0,   0,  1,  1,  1);
      cyc("async_rst",    0,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  0);
      cyc("rst_hold",     0,  1, 0, 0, 8,  1, 0,  0, 0,  0,   0,  1,  0,  0);
      cyc("rst_rel",      1,  1, 0, 0, 8,  1, 0,  0, 0,  0,   0,  1,  0,  0);
      cyc("iss_r12",      1,  1,12, 1, 0,  0, 0,  0, 0,  0,   0,  1,  0,  0);
      cyc("waw_r12",      1,  1,12, 1, 0,  0, 0,  0, 0,  0,   0,  0,  1,  0);
      cyc("waw_byp",      1,  1,12, 1, 0,  0, 0,  0, 1, 12,   0,  1,  1,  0);
      cyc("idle_f",       1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  1,  0);
      cyc("wb_r12",       1,  0, 0, 0, 0,  0, 0,  0, 1, 12,   0,  0,  1,  0);
      cyc("idle_g",       1,  0, 0, 0, 0,  0, 0,  0, 0,  0,   0,  0,  0,  0);

      // Let the monitor consume the remaining expectations, within a bounded wait.
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending got %0d want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dest_scoreboard
